// File: rtl/clk_freq_monitor.sv
// ---------------------------------------------------------------------------
// clk_freq_monitor
//
// Counts rising edges of an asynchronous clock (MON_CLK) over a fixed window
// of CLK cycles, reports each window's count with range faults, and runs a
// hysteretic lock qualifier over the stream of window results.
//
// Ports
//   CLK         in   system clock, all logic on its rising edge
//   RESET       in   synchronous, active-high reset (priority over EN)
//   EN          in   monitor enable; low clears the window and the lock state
//   MON_CLK     in   monitored clock, asynchronous to CLK
//   LOCK        out  monitored clock qualified (FSM in LOCKED or HOLD)
//   MEAS_COUNT  out  edge count of the last completed window
//   MEAS_VALID  out  one-cycle pulse when a new window result is loaded
//   FAULT_HI    out  last window count was above EXP_MAX
//   FAULT_LO    out  last window count was below EXP_MIN
// ---------------------------------------------------------------------------
module clk_freq_monitor #(
    parameter int CNT_W         = 16,
    parameter int WINDOW_CYCLES = 1000,
    parameter int EXP_MIN       = 9,
    parameter int EXP_MAX       = 11,
    parameter int LOCK_COUNT    = 4,
    parameter int UNLOCK_COUNT  = 2
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             EN,
    input  logic             MON_CLK,
    output logic             LOCK,
    output logic [CNT_W-1:0] MEAS_COUNT,
    output logic             MEAS_VALID,
    output logic             FAULT_HI,
    output logic             FAULT_LO
);

    localparam int               WIN_W    = $clog2(WINDOW_CYCLES);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        UNLOCKED,
        ACQUIRE,
        LOCKED,
        HOLD
    } state_t;

    // -----------------------------------------------------------------------
    // Synchronizer and rising-edge detect; runs independently of EN so the
    // pipeline is already settled when a window starts.
    // -----------------------------------------------------------------------
    logic sync1, sync2, hist;
    logic edge_pulse;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            hist  <= 1'b0;
        end else begin
            sync1 <= MON_CLK;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    assign edge_pulse = sync2 & ~hist;

    // -----------------------------------------------------------------------
    // Window and edge counters
    // -----------------------------------------------------------------------
    logic [WIN_W-1:0] win_cnt;
    logic [CNT_W-1:0] edge_cnt;
    logic [CNT_W-1:0] closing_count;
    logic             terminal;
    logic             in_range;

    assign terminal = EN && (win_cnt == WIN_LAST);

    // Edge count including this cycle's pulse, saturating; on the terminal
    // cycle this is the value the closing window reports.
    assign closing_count = (edge_pulse && (edge_cnt != CNT_MAX)) ? edge_cnt + 1'b1
                                                                 : edge_cnt;

    assign in_range = (closing_count >= CNT_W'(EXP_MIN)) &&
                      (closing_count <= CNT_W'(EXP_MAX));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            win_cnt    <= '0;
            edge_cnt   <= '0;
            MEAS_COUNT <= '0;
            MEAS_VALID <= 1'b0;
            FAULT_HI   <= 1'b0;
            FAULT_LO   <= 1'b0;
        end else if (!EN) begin
            // Results of the last completed window stay visible while idle.
            win_cnt    <= '0;
            edge_cnt   <= '0;
            MEAS_VALID <= 1'b0;
        end else begin
            MEAS_VALID <= terminal;
            if (terminal) begin
                win_cnt    <= '0;
                edge_cnt   <= '0;
                MEAS_COUNT <= closing_count;
                FAULT_HI   <= (closing_count > CNT_W'(EXP_MAX));
                FAULT_LO   <= (closing_count < CNT_W'(EXP_MIN));
            end else begin
                win_cnt    <= win_cnt + 1'b1;
                edge_cnt   <= closing_count;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Lock qualifier FSM; advances only on window results.
    // -----------------------------------------------------------------------
    state_t     state_q, state_d;
    logic [7:0] good_q, good_d;
    logic [7:0] bad_q, bad_d;

    always_ff @(posedge CLK) begin
        if (RESET || !EN) begin
            state_q <= UNLOCKED;
            good_q  <= '0;
            bad_q   <= '0;
            LOCK    <= 1'b0;
        end else begin
            state_q <= state_d;
            good_q  <= good_d;
            bad_q   <= bad_d;
            // Registered from the next state so LOCK moves with MEAS_VALID.
            LOCK    <= (state_d == LOCKED) || (state_d == HOLD);
        end
    end

    // NOTE: every output of this block is defaulted first, so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        bad_d   = bad_q;
        if (terminal) begin
            unique case (state_q)
                UNLOCKED: begin
                    if (in_range) begin
                        if (LOCK_COUNT == 1) begin
                            state_d = LOCKED;
                            good_d  = '0;
                        end else begin
                            state_d = ACQUIRE;
                            good_d  = 8'd1;
                        end
                    end
                end
                ACQUIRE: begin
                    if (in_range) begin
                        if (good_q + 8'd1 == 8'(LOCK_COUNT)) begin
                            state_d = LOCKED;
                            good_d  = '0;
                        end else begin
                            good_d  = good_q + 8'd1;
                        end
                    end else begin
                        state_d = UNLOCKED;
                        good_d  = '0;
                    end
                end
                LOCKED: begin
                    if (!in_range) begin
                        if (UNLOCK_COUNT == 1) begin
                            state_d = UNLOCKED;
                            bad_d   = '0;
                        end else begin
                            state_d = HOLD;
                            bad_d   = 8'd1;
                        end
                    end
                end
                HOLD: begin
                    if (in_range) begin
                        state_d = LOCKED;
                        bad_d   = '0;
                    end else if (bad_q + 8'd1 == 8'(UNLOCK_COUNT)) begin
                        state_d = UNLOCKED;
                        bad_d   = '0;
                    end else begin
                        bad_d   = bad_q + 8'd1;
                    end
                end
                default: state_d = UNLOCKED;
            endcase
        end
    end

endmodule
